i_mem_ctrl: RTL and testbench

I_MEM_CTRL -- requirements
Module: i_mem_ctrl

---
 rtl/lotr_pkg.sv | 16 +
 rtl/i_mem_ctrl_if.sv | 36 +++
 rtl/i_mem_ctrl.sv | 136 +++++++++++++
 tb/tb_i_mem_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/lotr_pkg.sv
// Shared ring definitions: request opcodes and the address-decode field
// used to route ring traffic to the instruction memory.
package lotr_pkg;

  typedef enum logic [1:0] {
    OP_NOP = 2'b00,
    OP_RD  = 2'b01,
    OP_WR  = 2'b10,
    OP_RSV = 2'b11
  } t_opcode;

  localparam int unsigned MSB_REGION   = 31;
  localparam int unsigned LSB_REGION   = 24;
  localparam logic [31:0] I_MEM_REGION = 32'h0000_0001;

endpackage

// File: rtl/i_mem_ctrl_if.sv
// Core fetch port and fabric-to-core ring port of the instruction memory.
// The slave modport is the memory side; master is the core/ring side.
interface i_mem_ctrl_if;

  logic [31:0]       PcQ100H;
  logic              RdEnableQ100H;
  logic [31:0]       InstFetchQ101H;
  logic              FetchReadyQ100H;
  logic              F2C_ReqValidQ503H;
  lotr_pkg::t_opcode F2C_ReqOpcodeQ503H;
  logic [31:0]       F2C_ReqAddressQ503H;
  logic [31:0]       F2C_ReqDataQ503H;
  logic [3:0]        F2C_ReqByteEnQ503H;
  logic              F2C_ReqReadyQ503H;
  logic              F2C_RspValidQ504H;
  logic [31:0]       F2C_RspDataQ504H;
  logic              F2C_RspReadyQ504H;
  logic              InitDoneQnnnH;

  modport slave (
    input  PcQ100H, RdEnableQ100H,
    input  F2C_ReqValidQ503H, F2C_ReqOpcodeQ503H, F2C_ReqAddressQ503H,
    input  F2C_ReqDataQ503H, F2C_ReqByteEnQ503H, F2C_RspReadyQ504H,
    output InstFetchQ101H, FetchReadyQ100H, F2C_ReqReadyQ503H,
    output F2C_RspValidQ504H, F2C_RspDataQ504H, InitDoneQnnnH
  );

  modport master (
    output PcQ100H, RdEnableQ100H,
    output F2C_ReqValidQ503H, F2C_ReqOpcodeQ503H, F2C_ReqAddressQ503H,
    output F2C_ReqDataQ503H, F2C_ReqByteEnQ503H, F2C_RspReadyQ504H,
    input  InstFetchQ101H, FetchReadyQ100H, F2C_ReqReadyQ503H,
    input  F2C_RspValidQ504H, F2C_RspDataQ504H, InitDoneQnnnH
  );

endinterface

// File: rtl/i_mem_ctrl.sv
// Instruction memory controller: NOP-fills the memory after reset, then
// serves 1-cycle core fetches and byte-enabled ring reads/writes.
module i_mem_ctrl #(
  parameter int unsigned MEM_WORDS  = 1024,
  parameter int unsigned RSP_DEPTH  = 2,
  parameter logic [31:0] INIT_WORD  = 32'h0000_0013,
  parameter int unsigned REGION_MSB = lotr_pkg::MSB_REGION,
  parameter int unsigned REGION_LSB = lotr_pkg::LSB_REGION,
  parameter logic [31:0] REGION_ID  = lotr_pkg::I_MEM_REGION
) (
  input logic         QClk,
  input logic         RstQnnnH,
  i_mem_ctrl_if.slave bus
);

  localparam int unsigned AW = $clog2(MEM_WORDS);
  localparam int unsigned PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int unsigned CW = $clog2(RSP_DEPTH + 1);
  localparam int unsigned RW = REGION_MSB - REGION_LSB + 1;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [31:0]   inst_q, inst_d;
  logic [31:0]   mem_q [MEM_WORDS];
  logic [31:0]   fifo_q [RSP_DEPTH];
  logic [31:0]   fifo_d [RSP_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic          run, hit, op_ok, req_ready, accept, push, pop, rsp_valid;
  logic [AW-1:0] pc_idx, ring_idx;
  logic          mem_we;
  logic [AW-1:0] mem_widx;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_wbe;
  logic          unused_addr_bits;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign run       = (state_q == ST_RUN) && RstQnnnH;
  assign pc_idx    = bus.PcQ100H[AW+1:2];
  assign ring_idx  = bus.F2C_ReqAddressQ503H[AW+1:2];
  assign hit       = bus.F2C_ReqAddressQ503H[REGION_MSB:REGION_LSB] == REGION_ID[RW-1:0];
  assign op_ok     = (bus.F2C_ReqOpcodeQ503H == lotr_pkg::OP_RD) ||
                     (bus.F2C_ReqOpcodeQ503H == lotr_pkg::OP_WR);
  // No read pipeline beyond the FIFO push, so occupancy alone bounds acceptance.
  assign req_ready = run && (count_q < CW'(RSP_DEPTH));
  assign accept    = bus.F2C_ReqValidQ503H && hit && op_ok && req_ready;
  assign push      = accept && (bus.F2C_ReqOpcodeQ503H == lotr_pkg::OP_RD);
  assign rsp_valid = RstQnnnH && (count_q != '0);
  assign pop       = rsp_valid && bus.F2C_RspReadyQ504H;

  assign bus.F2C_ReqReadyQ503H = req_ready;
  assign bus.F2C_RspValidQ504H = rsp_valid;
  assign bus.F2C_RspDataQ504H  = rsp_valid ? fifo_q[rd_ptr_q] : '0;
  assign bus.FetchReadyQ100H   = run;
  assign bus.InitDoneQnnnH     = run;
  assign bus.InstFetchQ101H    = RstQnnnH ? inst_q : INIT_WORD;
  assign unused_addr_bits      = ^{bus.PcQ100H, bus.F2C_ReqAddressQ503H};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    inst_d    = inst_q;
    mem_we    = 1'b0;
    mem_widx  = ring_idx;
    mem_wdata = bus.F2C_ReqDataQ503H;
    mem_wbe   = bus.F2C_ReqByteEnQ503H;
    case (state_q)
      ST_INIT: begin
        mem_we    = 1'b1;
        mem_widx  = cnt_q;
        mem_wdata = INIT_WORD;
        mem_wbe   = 4'hF;
        inst_d    = INIT_WORD;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == AW'(MEM_WORDS - 1)) state_d = ST_RUN;
      end
      ST_RUN: begin
        // mem_q is read before the same-edge write lands, giving old data on a collision.
        if (bus.RdEnableQ100H) inst_d = mem_q[pc_idx];
        if (accept && (bus.F2C_ReqOpcodeQ503H == lotr_pkg::OP_WR)) mem_we = 1'b1;
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      fifo_d[wr_ptr_q] = mem_q[ring_idx];
      wr_ptr_d         = ptr_inc(wr_ptr_q);
    end
    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge QClk) begin
    if (!RstQnnnH) begin
      state_q  <= ST_INIT;
      cnt_q    <= '0;
      inst_q   <= INIT_WORD;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      inst_q   <= inst_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
    fifo_q <= fifo_d;
  end

  always_ff @(posedge QClk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_wbe[b]) mem_q[mem_widx][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_i_mem_ctrl.sv
// Directed bench for i_mem_ctrl (16 words, 2-entry response FIFO) with
// hand-computed expected values.
module tb_i_mem_ctrl;

  localparam logic [31:0] HIT  = 32'h0100_0000;
  localparam logic [31:0] MISS = 32'h0200_0000;

  logic clk;
  logic rst_n;
  int   n_compared;
  int   n_mismatched;

  i_mem_ctrl_if bus_if ();

  i_mem_ctrl #(
    .MEM_WORDS(16),
    .RSP_DEPTH(2)
  ) dut (
    .QClk    (clk),
    .RstQnnnH(rst_n),
    .bus     (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_compared++;
    if (observed !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input lotr_pkg::t_opcode op,
                               input logic [31:0] addr, input logic [31:0] data,
                               input logic [3:0] be);
    bus_if.F2C_ReqValidQ503H   = valid;
    bus_if.F2C_ReqOpcodeQ503H  = op;
    bus_if.F2C_ReqAddressQ503H = addr;
    bus_if.F2C_ReqDataQ503H    = data;
    bus_if.F2C_ReqByteEnQ503H  = be;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input int word, input logic [31:0] expected, input string tag);
    bus_if.PcQ100H       = 32'(word * 4);
    bus_if.RdEnableQ100H = 1'b1;
    step();
    checkOutput(tag, bus_if.InstFetchQ101H, expected);
  endtask

  task automatic ring_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] be);
    applyStimulus(1'b1, lotr_pkg::OP_WR, addr, data, be);
    step();
    applyStimulus(1'b0, lotr_pkg::OP_NOP, '0, '0, '0);
  endtask

  task automatic sweep_and_check(input string tag);
    for (int i = 1; i <= 16; i++) begin
      step();
      if (i == 15) checkOutput({tag, "_done_at15"}, 32'(bus_if.InitDoneQnnnH), 32'd0);
      if (i == 15) checkOutput({tag, "_rdy_at15"}, 32'(bus_if.F2C_ReqReadyQ503H), 32'd0);
    end
    checkOutput({tag, "_done_at16"}, 32'(bus_if.InitDoneQnnnH), 32'd1);
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    rst_n        = 1'b0;
    bus_if.PcQ100H           = '0;
    bus_if.RdEnableQ100H     = 1'b0;
    bus_if.F2C_RspReadyQ504H = 1'b0;
    applyStimulus(1'b0, lotr_pkg::OP_NOP, '0, '0, '0);
    repeat (3) step();

    checkOutput("rst_req_ready", 32'(bus_if.F2C_ReqReadyQ503H), 32'd0);
    checkOutput("rst_rsp_valid", 32'(bus_if.F2C_RspValidQ504H), 32'd0);
    checkOutput("rst_rsp_data", bus_if.F2C_RspDataQ504H, 32'd0);
    checkOutput("rst_fetch_ready", 32'(bus_if.FetchReadyQ100H), 32'd0);
    checkOutput("rst_init_done", 32'(bus_if.InitDoneQnnnH), 32'd0);
    checkOutput("rst_inst", bus_if.InstFetchQ101H, 32'h0000_0013);

    rst_n = 1'b1;
    sweep_and_check("init");
    checkOutput("run_fetch_ready", 32'(bus_if.FetchReadyQ100H), 32'd1);
    checkOutput("run_req_ready", 32'(bus_if.F2C_ReqReadyQ503H), 32'd1);
    for (int w = 0; w < 16; w++) fetch(w, 32'h0000_0013, $sformatf("nop_w%0d", w));

    // Byte-enabled merge onto the NOP pattern, plus the hold behaviour.
    bus_if.RdEnableQ100H = 1'b0;
    ring_write(HIT | 32'h8, 32'hAABB_CCDD, 4'b0101);
    checkOutput("wr_no_rsp", 32'(bus_if.F2C_RspValidQ504H), 32'd0);
    fetch(2, 32'h00BB_00DD, "be_merge");
    bus_if.PcQ100H       = 32'h14;
    bus_if.RdEnableQ100H = 1'b0;
    step();
    checkOutput("fetch_hold", bus_if.InstFetchQ101H, 32'h00BB_00DD);

    ring_write(HIT | 32'h24, 32'hFFFF_FFFF, 4'b0000);
    fetch(9, 32'h0000_0013, "be_zero_noop");
    ring_write(MISS | 32'h4, 32'hDEAD_BEEF, 4'b1111);
    fetch(1, 32'h0000_0013, "miss_wr_noop");

    applyStimulus(1'b1, lotr_pkg::OP_WR, HIT | 32'h14, 32'h1234_5678, 4'b1111);
    fetch(5, 32'h0000_0013, "rbw_old");
    applyStimulus(1'b0, lotr_pkg::OP_NOP, '0, '0, '0);
    fetch(5, 32'h1234_5678, "rbw_new");
    bus_if.RdEnableQ100H = 1'b0;

    ring_write(HIT | 32'h28, 32'hA000_000A, 4'b1111);
    ring_write(HIT | 32'h2C, 32'hB000_000B, 4'b1111);
    ring_write(HIT | 32'h30, 32'hC000_000C, 4'b1111);

    // Back-pressure: two reads fill the FIFO, the third must stall.
    bus_if.F2C_RspReadyQ504H = 1'b0;
    applyStimulus(1'b1, lotr_pkg::OP_RD, HIT | 32'h28, '0, '0);
    checkOutput("bp_ready0", 32'(bus_if.F2C_ReqReadyQ503H), 32'd1);
    step();
    applyStimulus(1'b1, lotr_pkg::OP_RD, HIT | 32'h2C, '0, '0);
    checkOutput("bp_ready1", 32'(bus_if.F2C_ReqReadyQ503H), 32'd1);
    step();
    applyStimulus(1'b1, lotr_pkg::OP_RD, HIT | 32'h30, '0, '0);
    checkOutput("bp_ready_full", 32'(bus_if.F2C_ReqReadyQ503H), 32'd0);
    step();
    checkOutput("bp_head0", bus_if.F2C_RspDataQ504H, 32'hA000_000A);
    applyStimulus(1'b0, lotr_pkg::OP_NOP, '0, '0, '0);
    bus_if.F2C_RspReadyQ504H = 1'b1;
    step();
    checkOutput("bp_head1", bus_if.F2C_RspDataQ504H, 32'hB000_000B);
    step();
    checkOutput("bp_drained", 32'(bus_if.F2C_RspValidQ504H), 32'd0);
    applyStimulus(1'b1, lotr_pkg::OP_RD, HIT | 32'h30, '0, '0);
    checkOutput("bp_ready_again", 32'(bus_if.F2C_ReqReadyQ503H), 32'd1);
    step();
    applyStimulus(1'b0, lotr_pkg::OP_NOP, '0, '0, '0);
    checkOutput("bp_third", bus_if.F2C_RspDataQ504H, 32'hC000_000C);
    step();
    checkOutput("bp_third_popped", 32'(bus_if.F2C_RspValidQ504H), 32'd0);

    // Simultaneous push/pop with a concurrent core fetch.
    applyStimulus(1'b1, lotr_pkg::OP_RD, HIT | 32'h28, '0, '0);
    fetch(5, 32'h1234_5678, "rd_and_fetch");
    applyStimulus(1'b1, lotr_pkg::OP_RD, HIT | 32'h2C, '0, '0);
    checkOutput("pp_head0", bus_if.F2C_RspDataQ504H, 32'hA000_000A);
    step();
    applyStimulus(1'b0, lotr_pkg::OP_NOP, '0, '0, '0);
    checkOutput("pp_valid", 32'(bus_if.F2C_RspValidQ504H), 32'd1);
    checkOutput("pp_head1", bus_if.F2C_RspDataQ504H, 32'hB000_000B);
    step();
    checkOutput("pp_empty", 32'(bus_if.F2C_RspValidQ504H), 32'd0);
    bus_if.RdEnableQ100H = 1'b0;

    // Address wrap and region miss.
    ring_write(HIT | 32'hC, 32'h3333_3333, 4'b1111);
    bus_if.F2C_RspReadyQ504H = 1'b0;
    applyStimulus(1'b1, lotr_pkg::OP_RD, HIT | 32'h4C, '0, '0);
    step();
    applyStimulus(1'b0, lotr_pkg::OP_NOP, '0, '0, '0);
    checkOutput("wrap_rd", bus_if.F2C_RspDataQ504H, 32'h3333_3333);
    bus_if.F2C_RspReadyQ504H = 1'b1;
    step();
    applyStimulus(1'b1, lotr_pkg::OP_RD, MISS | 32'hC, '0, '0);
    step();
    applyStimulus(1'b0, lotr_pkg::OP_NOP, '0, '0, '0);
    checkOutput("miss_rd_no_rsp", 32'(bus_if.F2C_RspValidQ504H), 32'd0);

    // Reset with a pending response, then again mid-sweep at counter 7.
    bus_if.F2C_RspReadyQ504H = 1'b0;
    applyStimulus(1'b1, lotr_pkg::OP_RD, HIT | 32'h28, '0, '0);
    step();
    applyStimulus(1'b0, lotr_pkg::OP_NOP, '0, '0, '0);
    checkOutput("pend_valid", 32'(bus_if.F2C_RspValidQ504H), 32'd1);
    rst_n = 1'b0;
    step();
    checkOutput("rst_flush", 32'(bus_if.F2C_RspValidQ504H), 32'd0);
    checkOutput("rst_done_low", 32'(bus_if.InitDoneQnnnH), 32'd0);
    rst_n = 1'b1;
    repeat (7) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    sweep_and_check("resweep");
    checkOutput("resweep_rsp", 32'(bus_if.F2C_RspValidQ504H), 32'd0);
    fetch(5, 32'h0000_0013, "resweep_w5");
    fetch(2, 32'h0000_0013, "resweep_w2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
